// File: rtl/slot_pkg.sv
// Shared types and constants for the slot machine spin controller and its
// payout evaluator.
package slot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPIN  = 3'd1,
    ST_STOP1 = 3'd2,
    ST_STOP2 = 3'd3,
    ST_EVAL  = 3'd4,
    ST_PAY   = 3'd5
  } spin_state_t;

  localparam int              SYM_W        = 4;
  localparam logic [SYM_W-1:0] JACKPOT_SYM = 4'd7;
  localparam int              MULT_JACKPOT = 20;
  localparam int              MULT_TRIPLE  = 10;
  localparam int              MULT_PAIR    = 2;

endpackage

// File: rtl/slot_payout.sv
// Combinational payout evaluator: three symbols and a bet in, saturated win
// amount out. Also used by the display/score logic.
module slot_payout
  import slot_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [SYM_W-1:0]    i_sym0,
  input  logic [SYM_W-1:0]    i_sym1,
  input  logic [SYM_W-1:0]    i_sym2,
  input  logic [CREDIT_W-1:0] i_bet,
  output logic [CREDIT_W-1:0] o_payout
);

  localparam int WIDE_W = CREDIT_W + 5;

  logic              w_eq01, w_eq12, w_eq02;
  logic [4:0]        w_mult;
  logic [WIDE_W-1:0] w_wide;

  // Pick the multiplier from the symbol pattern, multiply wide, then clamp.
  always_comb begin
    w_eq01   = (i_sym0 == i_sym1);
    w_eq12   = (i_sym1 == i_sym2);
    w_eq02   = (i_sym0 == i_sym2);
    w_mult   = 5'd0;
    if (w_eq01 && w_eq12) begin
      if (i_sym0 == JACKPOT_SYM) begin
        w_mult = 5'(MULT_JACKPOT);
      end else begin
        w_mult = 5'(MULT_TRIPLE);
      end
    end else if (w_eq01 || w_eq12 || w_eq02) begin
      w_mult = 5'(MULT_PAIR);
    end else begin
      w_mult = 5'd0;
    end
    w_wide = WIDE_W'(w_mult) * WIDE_W'(i_bet);
    if (|w_wide[WIDE_W-1:CREDIT_W]) begin
      o_payout = '1;
    end else begin
      o_payout = w_wide[CREDIT_W-1:0];
    end
  end

endmodule

// File: rtl/slot_spin_ctrl.sv
// Spin controller: starts the three reels, stops them one at a time on an
// operator press or timeout, evaluates the symbols and keeps the credit balance.
module slot_spin_ctrl
  import slot_pkg::*;
#(
  parameter int CREDIT_W      = 8,
  parameter int START_CREDITS = 10,
  parameter int BET           = 1,
  parameter int STOP_DELAY    = 16
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_spin,
  input  logic                i_stop,
  input  logic [SYM_W-1:0]    i_reel0,
  input  logic [SYM_W-1:0]    i_reel1,
  input  logic [SYM_W-1:0]    i_reel2,
  output logic                o_run0,
  output logic                o_run1,
  output logic                o_run2,
  output logic [SYM_W-1:0]    o_result0,
  output logic [SYM_W-1:0]    o_result1,
  output logic [SYM_W-1:0]    o_result2,
  output logic [CREDIT_W-1:0] o_credits,
  output logic [CREDIT_W-1:0] o_payout,
  output logic                o_win,
  output logic                o_busy
);

  localparam int                CNT_W   = $clog2(STOP_DELAY + 1);
  localparam logic [CREDIT_W-1:0] BET_C   = CREDIT_W'(BET);
  localparam logic [CREDIT_W-1:0] START_C = CREDIT_W'(START_CREDITS);

  spin_state_t         r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_stop_q;
  logic [2:0]          r_run, w_run_nxt;
  logic [SYM_W-1:0]    r_result0, r_result1, r_result2;
  logic [SYM_W-1:0]    w_result0_nxt, w_result1_nxt, w_result2_nxt;
  logic [CREDIT_W-1:0] r_credits, w_credits_nxt;
  logic [CREDIT_W-1:0] r_payout, w_payout_nxt;
  logic                r_win, w_win_nxt;
  logic                r_busy, w_busy_nxt;
  logic [CREDIT_W-1:0] w_payout_calc;
  logic [CREDIT_W:0]   w_credit_sum;
  logic                w_press, w_leave;

  slot_payout #(.CREDIT_W(CREDIT_W)) u_payout (
    .i_sym0   (i_reel0),
    .i_sym1   (i_reel1),
    .i_sym2   (i_reel2),
    .i_bet    (BET_C),
    .o_payout (w_payout_calc)
  );

  assign w_press      = i_stop & ~r_stop_q;
  assign w_leave      = (r_cnt == CNT_W'(STOP_DELAY - 1)) | w_press;
  assign w_credit_sum = {1'b0, r_credits} + {1'b0, r_payout};

  // Next-state and next-output logic; everything holds unless a state acts.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_run_nxt     = r_run;
    w_result0_nxt = r_result0;
    w_result1_nxt = r_result1;
    w_result2_nxt = r_result2;
    w_credits_nxt = r_credits;
    w_payout_nxt  = r_payout;
    w_win_nxt     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_spin && (r_credits >= BET_C)) begin
          w_credits_nxt = r_credits - BET_C;
          w_run_nxt     = 3'b111;
          w_cnt_nxt     = '0;
          w_state_nxt   = ST_SPIN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SPIN, ST_STOP1, ST_STOP2: begin
        if (w_leave) begin
          w_cnt_nxt = '0;
          if (r_state == ST_SPIN) begin
            w_run_nxt   = r_run & 3'b110;
            w_state_nxt = ST_STOP1;
          end else if (r_state == ST_STOP1) begin
            w_run_nxt   = r_run & 3'b100;
            w_state_nxt = ST_STOP2;
          end else begin
            w_run_nxt   = 3'b000;
            w_state_nxt = ST_EVAL;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_EVAL: begin
        w_result0_nxt = i_reel0;
        w_result1_nxt = i_reel1;
        w_result2_nxt = i_reel2;
        w_payout_nxt  = w_payout_calc;
        w_state_nxt   = ST_PAY;
      end
      ST_PAY: begin
        if (w_credit_sum[CREDIT_W]) begin
          w_credits_nxt = '1;
        end else begin
          w_credits_nxt = w_credit_sum[CREDIT_W-1:0];
        end
        w_win_nxt   = (r_payout != '0);
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_run_nxt   = 3'b000;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and output registers; a mid-spin reset does not refund the bet.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_stop_q  <= 1'b0;
      r_run     <= 3'b000;
      r_result0 <= '0;
      r_result1 <= '0;
      r_result2 <= '0;
      r_credits <= START_C;
      r_payout  <= '0;
      r_win     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_stop_q  <= i_stop;
      r_run     <= w_run_nxt;
      r_result0 <= w_result0_nxt;
      r_result1 <= w_result1_nxt;
      r_result2 <= w_result2_nxt;
      r_credits <= w_credits_nxt;
      r_payout  <= w_payout_nxt;
      r_win     <= w_win_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign o_run0    = r_run[0];
  assign o_run1    = r_run[1];
  assign o_run2    = r_run[2];
  assign o_result0 = r_result0;
  assign o_result1 = r_result1;
  assign o_result2 = r_result2;
  assign o_credits = r_credits;
  assign o_payout  = r_payout;
  assign o_win     = r_win;
  assign o_busy    = r_busy;

endmodule
